// File: rtl/slt_cmp_pkg.sv
// Shared types for the set-less-than / compare datapath and its arbiter.
// Holds the op encoding, the default operand width and the round-robin pointer helper.
package slt_cmp_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [1:0] {
        CMP_SLTU = 2'b00,
        CMP_SLT  = 2'b01,
        CMP_SEQ  = 2'b10,
        CMP_RSVD = 2'b11
    } cmp_op_e;

    // Next round-robin start position after index idx wins, out of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/slt_cmp_core.sv
// Combinational compare unit: produces {XLEN-1 zeros, flag} for SLTU, SLT and SEQ.
// The reserved op yields a zero result rather than trapping.
module slt_cmp_core
    import slt_cmp_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  cmp_op_e           op_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [XLEN-1:0]   rd_o
);

    logic flag;
    logic ltu;
    logic lt_low;

    assign ltu    = rs1_i < rs2_i;
    assign lt_low = rs1_i[XLEN-2:0] < rs2_i[XLEN-2:0];

    always_comb begin
        flag = 1'b0;
        unique case (op_i)
            CMP_SLTU: flag = ltu;
            // Differing signs decide on rs1's sign alone; same signs reduce to unsigned.
            CMP_SLT:  flag = (rs1_i[XLEN-1] != rs2_i[XLEN-1]) ? rs1_i[XLEN-1] : lt_low;
            CMP_SEQ:  flag = (rs1_i == rs2_i);
            CMP_RSVD: flag = 1'b0;
            default:  flag = 1'b0;
        endcase
    end

    assign rd_o = {{(XLEN-1){1'b0}}, flag};

endmodule

// File: rtl/slt_cmp_arbiter.sv
// Round-robin arbiter sharing one compare datapath among NUM_REQ requesters,
// with a single registered response slot tagged by the winning requester's id.
module slt_cmp_arbiter
    import slt_cmp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = XLEN_DEF,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [2*NUM_REQ-1:0]      req_op_i,
    input  logic [XLEN*NUM_REQ-1:0]   req_rs1_i,
    input  logic [XLEN*NUM_REQ-1:0]   req_rs2_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [XLEN-1:0]           rsp_rd_o
);

    logic [ID_W-1:0] rr_q, rr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_rd_q, rsp_rd_d;

    logic            can_accept;
    logic            found;
    logic            transfer;
    logic [ID_W-1:0] winner;
    int unsigned     idx;

    cmp_op_e         op_sel;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;
    logic [XLEN-1:0] core_rd;

    assign can_accept = !rsp_valid_q || rsp_ready_i;

    // Search upward from the rr pointer with wrap; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid_i[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign transfer = found && can_accept && rst_ni;

    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        op_sel  = CMP_SLTU;
        rs1_sel = '0;
        rs2_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                op_sel  = cmp_op_e'(req_op_i[2*k +: 2]);
                rs1_sel = req_rs1_i[k*XLEN +: XLEN];
                rs2_sel = req_rs2_i[k*XLEN +: XLEN];
            end
        end
    end

    slt_cmp_core #(
        .XLEN (XLEN)
    ) u_core (
        .op_i  (op_sel),
        .rs1_i (rs1_sel),
        .rs2_i (rs2_sel),
        .rd_o  (core_rd)
    );

    always_comb begin
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rd_d    = rsp_rd_q;
        if (transfer) begin
            rr_d        = ID_W'(rr_next(32'(winner), NUM_REQ));
            rsp_valid_d = 1'b1;
            rsp_id_d    = winner;
            rsp_rd_d    = core_rd;
        end else if (rsp_ready_i) begin
            // Consumer took the result; payload is held for observability.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rd_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_rd_o    = rsp_rd_q;

endmodule

// File: tb/tb_slt_cmp_arbiter.sv
// Scoreboard bench for slt_cmp_arbiter: a grant/compare model pushes expected responses
// on each accept, and the negedge monitor pops and compares them as the DUT responds.
module tb_slt_cmp_arbiter;

    localparam int N    = 2;
    localparam int XL   = 32;
    localparam int IDW  = $clog2(N);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [XL-1:0]  rd;
    } exp_t;

    logic              clk;
    logic              rst_ni;
    logic [N-1:0]      vld;
    logic [1:0]        op [N];
    logic [XL-1:0]     a  [N];
    logic [XL-1:0]     b  [N];
    logic [2*N-1:0]    req_op;
    logic [XL*N-1:0]   req_rs1;
    logic [XL*N-1:0]   req_rs2;
    logic [N-1:0]      req_ready_o;
    logic              rsp_valid_o;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id_o;
    logic [XL-1:0]     rsp_rd_o;

    exp_t          sb[$];
    exp_t          held;
    int            exp_rr;
    logic [N-1:0]  fired;
    int            n_acc;
    int            n_checks;
    int            n_errors;

    slt_cmp_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (vld),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op),
        .req_rs1_i   (req_rs1),
        .req_rs2_i   (req_rs2),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id_o),
        .rsp_rd_o    (rsp_rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_op  = '0;
        req_rs1 = '0;
        req_rs2 = '0;
        for (int k = 0; k < N; k++) begin
            req_op[2*k +: 2]   = op[k];
            req_rs1[k*XL +: XL] = a[k];
            req_rs2[k*XL +: XL] = b[k];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XL-1:0] ref_rd(input logic [1:0] o, input logic [XL-1:0] x,
                                             input logic [XL-1:0] y);
        case (o)
            2'b00:   return (x < y) ? 1 : 0;
            2'b01:   return ($signed(x) < $signed(y)) ? 1 : 0;
            2'b10:   return (x == y) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Monitor: inputs only change just after posedge, so negedge sees settled handshakes.
    always @(negedge clk) begin : mon
        logic         exp_valid;
        logic         can;
        logic [N-1:0] eg;
        int           j;
        int           w;
        exp_t         e;
        if (!rst_ni) begin
            check_eq("rst_req_ready", 64'(req_ready_o), 0);
            check_eq("rst_rsp_valid", 64'(rsp_valid_o), 0);
            sb.delete();
            exp_rr = 0;
            held   = '0;
            fired  = '0;
        end else begin
            exp_valid = (sb.size() != 0);
            check_eq("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
            if (exp_valid) begin
                check_eq("rsp_id", 64'(rsp_id_o), 64'(sb[0].id));
                check_eq("rsp_rd", 64'(rsp_rd_o), 64'(sb[0].rd));
            end else begin
                check_eq("held_id", 64'(rsp_id_o), 64'(held.id));
                check_eq("held_rd", 64'(rsp_rd_o), 64'(held.rd));
            end
            can = !exp_valid || rsp_ready;
            eg  = '0;
            w   = -1;
            for (int i = 0; i < N; i++) begin
                j = (exp_rr + i) % N;
                if (w < 0 && vld[j] && can) begin
                    w     = j;
                    eg[j] = 1'b1;
                end
            end
            check_eq("req_ready", 64'(req_ready_o), 64'(eg));
            if (exp_valid && rsp_ready) begin
                void'(sb.pop_front());
            end
            fired = vld & req_ready_o;
            if (w >= 0) begin
                e.id = IDW'(w);
                e.rd = ref_rd(op[w], a[w], b[w]);
                sb.push_back(e);
                held   = e;
                exp_rr = (w + 1) % N;
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fired[k]) vld[k] = 1'b0;
        end
    endtask

    task automatic raise(input int k, input logic [1:0] o, input logic [XL-1:0] x,
                         input logic [XL-1:0] y);
        vld[k] = 1'b1;
        op[k]  = o;
        a[k]   = x;
        b[k]   = y;
    endtask

    function automatic logic [XL-1:0] rand_operand(input int mode);
        logic [XL-1:0] edges [4];
        edges[0] = 32'h8000_0000;
        edges[1] = 32'h7FFF_FFFF;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h0000_0000;
        case (mode)
            0:       return $urandom;
            1:       return edges[$urandom_range(0, 3)];
            default: return XL'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic raise_random(input int k);
        logic [XL-1:0] x;
        logic [XL-1:0] y;
        x = rand_operand($urandom_range(0, 2));
        y = ($urandom_range(0, 3) == 0) ? x : rand_operand($urandom_range(0, 2));
        raise(k, 2'($urandom_range(0, 3)), x, y);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int start;
        int cyc;
        n_checks  = 0;
        n_errors  = 0;
        n_acc     = 0;
        rst_ni    = 1'b0;
        vld       = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            op[k] = 2'b00;
            a[k]  = '0;
            b[k]  = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Single requests on each port and the basic ops.
        raise(0, 2'b00, 32'hFFFF_FFFF, 32'h1);
        step();
        step();
        raise(1, 2'b01, 32'hFFFF_FFFF, 32'h1);
        step();
        raise(1, 2'b10, 32'd5, 32'd5);
        step();
        step();

        // Both requesters continuously valid: strict alternation, one per cycle.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < N; k++) if (!vld[k]) raise_random(k);
            step();
        end

        // Consumer stall with a pending requester, then release.
        for (int k = 0; k < N; k++) if (!vld[k]) raise_random(k);
        rsp_ready = 1'b0;
        repeat (4) step();
        rsp_ready = 1'b1;
        repeat (3) step();
        vld = '0;
        step();

        // Reserved op still produces a zero response.
        raise(0, 2'b11, 32'd3, 32'd7);
        step();
        step();

        // Asynchronous reset while stalled; requester 0 must win first afterwards.
        for (int k = 0; k < N; k++) if (!vld[k]) raise_random(k);
        rsp_ready = 1'b0;
        step();
        step();
        for (int k = 0; k < N; k++) if (!vld[k]) raise_random(k);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("async_rst_rsp_valid", 64'(rsp_valid_o), 0);
        check_eq("async_rst_req_ready", 64'(req_ready_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        check_eq("post_rst_req0_first", 64'(req_ready_o), 64'(2'b01));
        rsp_ready = 1'b1;
        step();
        step();

        // Random traffic with random back-pressure.
        start = n_acc;
        cyc   = 0;
        while ((n_acc - start) < 1000 && cyc < 20000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && $urandom_range(0, 2) != 0) raise_random(k);
            end
            step();
            cyc++;
        end
        check_eq("random_accepts", 64'((n_acc - start) >= 1000), 1);

        vld       = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        check_eq("sb_drained", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
